// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an I-cache and a D-cache, with alternating priority when both request.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_strobe_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  output logic                  i_done_o,
  output logic [LINE_WIDTH-1:0] i_data_o,
  input  logic                  d_strobe_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic                  d_rw_i,
  input  logic [LINE_WIDTH-1:0] d_data_i,
  output logic                  d_done_o,
  output logic [LINE_WIDTH-1:0] d_data_o,
  output logic                  m_strobe_o,
  output logic [ADDR_WIDTH-1:0] m_addr_o,
  output logic                  m_rw_o,
  output logic [LINE_WIDTH-1:0] m_data_o,
  input  logic                  m_done_i,
  input  logic [LINE_WIDTH-1:0] m_data_i
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic i_pend, d_pend, last_d, grant_d, d_rw_q;
  logic [ADDR_WIDTH-1:0] i_addr_q, d_addr_q;
  logic [LINE_WIDTH-1:0] d_wdata_q;
  logic sel_d, i_resp, d_resp, i_take, d_take;
  always_comb begin
    sel_d  = d_pend & (~i_pend | ~last_d);
    i_resp = (state == RESP) & ~grant_d;
    d_resp = (state == RESP) & grant_d;
    // a strobe during its own completion cycle re-arms the flag
    i_take = i_strobe_i & (~i_pend | i_resp);
    d_take = d_strobe_i & (~d_pend | d_resp);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      i_pend    <= 1'b0;
      d_pend    <= 1'b0;
      i_addr_q  <= '0;
      d_addr_q  <= '0;
      d_rw_q    <= 1'b0;
      d_wdata_q <= '0;
    end else begin
      if (i_take) begin
        i_pend   <= 1'b1;
        i_addr_q <= i_addr_i;
      end else if (i_resp) i_pend <= 1'b0;
      if (d_take) begin
        d_pend    <= 1'b1;
        d_addr_q  <= d_addr_i;
        d_rw_q    <= d_rw_i;
        d_wdata_q <= d_data_i;
      end else if (d_resp) d_pend <= 1'b0;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      grant_d    <= 1'b0;
      last_d     <= 1'b1;
      m_strobe_o <= 1'b0;
      m_addr_o   <= '0;
      m_rw_o     <= 1'b0;
      m_data_o   <= '0;
      i_done_o   <= 1'b0;
      d_done_o   <= 1'b0;
      i_data_o   <= '0;
      d_data_o   <= '0;
    end else begin
      case (state)
        IDLE: if (i_pend | d_pend) begin
          state      <= ISSUE;
          grant_d    <= sel_d;
          last_d     <= sel_d;
          m_strobe_o <= 1'b1;
          m_addr_o   <= sel_d ? d_addr_q : i_addr_q;
          m_rw_o     <= sel_d & d_rw_q;
          m_data_o   <= sel_d ? d_wdata_q : '0;
        end
        ISSUE: begin
          m_strobe_o <= 1'b0;
          state      <= WAIT;
        end
        WAIT: if (m_done_i) begin
          state <= RESP;
          if (grant_d) begin
            d_data_o <= m_data_i;
            d_done_o <= 1'b1;
          end else begin
            i_data_o <= m_data_i;
            i_done_o <= 1'b1;
          end
        end
        RESP: begin
          i_done_o <= 1'b0;
          d_done_o <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with queued expectations, checked by an independent output monitor.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_strobe_i = 1'b0, d_strobe_i = 1'b0, d_rw_i = 1'b0, m_done_i = 1'b0;
  logic [AW-1:0] i_addr_i = '0, d_addr_i = '0;
  logic [LW-1:0] d_data_i = '0, m_data_i = '0;
  logic i_done_o, d_done_o, m_strobe_o, m_rw_o;
  logic [LW-1:0] i_data_o, d_data_o, m_data_o;
  logic [AW-1:0] m_addr_o;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_strobe_i(i_strobe_i), .i_addr_i(i_addr_i), .i_done_o(i_done_o), .i_data_o(i_data_o),
    .d_strobe_i(d_strobe_i), .d_addr_i(d_addr_i), .d_rw_i(d_rw_i), .d_data_i(d_data_i),
    .d_done_o(d_done_o), .d_data_o(d_data_o),
    .m_strobe_o(m_strobe_o), .m_addr_o(m_addr_o), .m_rw_o(m_rw_o), .m_data_o(m_data_o),
    .m_done_i(m_done_i), .m_data_i(m_data_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          rw;
    logic [LW-1:0] data;
    int            at;
  } req_t;

  req_t exp_m[$];
  logic [LW-1:0] exp_i[$], exp_d[$], mem_rsp[$];
  req_t cur;
  bit in_flight = 0;
  int cyc = 0, mdone_cyc = -10, i_cnt = 0, d_cnt = 0, checks = 0, errors = 0;

  localparam logic [LW-1:0] A5 = {32{8'hA5}};
  localparam logic [LW-1:0] WD = {8{32'h12345678}};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_issue(input logic [AW-1:0] a, input logic rw, input logic [LW-1:0] d, input int at);
    req_t r;
    r = '{a, rw, d, at};
    exp_m.push_back(r);
  endtask

  task automatic wait_cnt(input int ni, input int nd);
    for (int k = 0; k < 200 && (i_cnt < ni || d_cnt < nd); k++) tick();
    repeat (6) tick();
    chk("i_done_count", LW'(i_cnt), LW'(ni));
    chk("d_done_count", LW'(d_cnt), LW'(nd));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_m_strobe"}, LW'(m_strobe_o), '0);
    chk({tag, "_m_addr"}, LW'(m_addr_o), '0);
    chk({tag, "_m_rw"}, LW'(m_rw_o), '0);
    chk({tag, "_m_data"}, m_data_o, '0);
    chk({tag, "_dones"}, LW'({i_done_o, d_done_o}), '0);
    chk({tag, "_i_data"}, i_data_o, '0);
    chk({tag, "_d_data"}, d_data_o, '0);
  endtask

  // memory model: completes each request three cycles after its strobe
  initial forever begin
    @(negedge clk);
    if (rst_n && m_strobe_o) begin
      repeat (3) @(posedge clk);
      #1;
      m_data_i  = mem_rsp.size() > 0 ? mem_rsp.pop_front() : '0;
      m_done_i  = 1'b1;
      mdone_cyc = cyc;
      @(posedge clk);
      #1 m_done_i = 1'b0;
    end
  end

  always @(negedge clk) if (rst_n) begin
    if (m_strobe_o) begin
      if (exp_m.size() == 0) chk("spurious_m_strobe", LW'(1), '0);
      else begin
        cur = exp_m.pop_front();
        in_flight = 1;
        chk("m_addr", LW'(m_addr_o), LW'(cur.addr));
        chk("m_rw", LW'(m_rw_o), LW'(cur.rw));
        if (cur.rw) chk("m_data", m_data_o, cur.data);
        if (cur.at >= 0) chk("m_strobe_cycle", LW'(cyc), LW'(cur.at));
      end
    end
    if (m_done_i && in_flight) begin
      chk("m_addr_held", LW'(m_addr_o), LW'(cur.addr));
      chk("m_rw_held", LW'(m_rw_o), LW'(cur.rw));
      if (cur.rw) chk("m_data_held", m_data_o, cur.data);
      in_flight = 0;
    end
    if (i_done_o) begin
      i_cnt++;
      if (exp_i.size() == 0) chk("unexpected_i_done", LW'(1), '0);
      else chk("i_data", i_data_o, exp_i.pop_front());
      chk("i_done_latency", LW'(cyc), LW'(mdone_cyc + 1));
    end
    if (d_done_o) begin
      d_cnt++;
      if (exp_d.size() == 0) chk("unexpected_d_done", LW'(1), '0);
      else chk("d_data", d_data_o, exp_d.pop_front());
      chk("d_done_latency", LW'(cyc), LW'(mdone_cyc + 1));
    end
    if (i_done_o || d_done_o) chk("done_overlap", LW'(i_done_o & d_done_o), '0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    repeat (2) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();
    // single I read
    expect_issue(32'h1000, 1'b0, '0, cyc + 2);
    mem_rsp.push_back(A5);
    exp_i.push_back(A5);
    i_strobe_i = 1'b1; i_addr_i = 32'h1000; tick(); i_strobe_i = 1'b0;
    wait_cnt(1, 0);
    // D write
    expect_issue(32'h2000, 1'b1, WD, cyc + 2);
    mem_rsp.push_back({8{32'hCAFE0002}});
    exp_d.push_back({8{32'hCAFE0002}});
    d_strobe_i = 1'b1; d_addr_i = 32'h2000; d_rw_i = 1'b1; d_data_i = WD; tick();
    d_strobe_i = 1'b0; d_rw_i = 1'b0;
    wait_cnt(1, 1);
    chk("i_data_hold", i_data_o, A5);
    // reset during WAIT discards the request
    expect_issue(32'h5000, 1'b0, '0, cyc + 2);
    mem_rsp.push_back({8{32'hDEAD0005}});
    i_strobe_i = 1'b1; i_addr_i = 32'h5000; tick(); i_strobe_i = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) if (m_strobe_o) seen = 1; else tick();
    chk("reset_test_strobe_seen", LW'(seen), LW'(1));
    tick();
    #2 rst_n = 1'b0;
    #1 in_flight = 0;
    chk_zero("midreset");
    tick();
    rst_n = 1'b1;
    wait_cnt(1, 1);
    // contested pair after reset: I first
    expect_issue(32'h6000, 1'b0, '0, cyc + 2);
    expect_issue(32'h7000, 1'b0, '0, cyc + 8);
    mem_rsp.push_back({8{32'h11110006}});
    mem_rsp.push_back({8{32'h22220007}});
    exp_i.push_back({8{32'h11110006}});
    exp_d.push_back({8{32'h22220007}});
    i_strobe_i = 1'b1; i_addr_i = 32'h6000;
    d_strobe_i = 1'b1; d_addr_i = 32'h7000; d_rw_i = 1'b0; tick();
    i_strobe_i = 1'b0; d_strobe_i = 1'b0;
    wait_cnt(2, 2);
    // duplicate I strobe while pending is ignored
    expect_issue(32'h3000, 1'b0, '0, cyc + 2);
    mem_rsp.push_back({8{32'h33330003}});
    exp_i.push_back({8{32'h33330003}});
    i_strobe_i = 1'b1; i_addr_i = 32'h3000; tick();
    i_addr_i = 32'h4000; tick();
    i_strobe_i = 1'b0;
    wait_cnt(3, 2);
    // contested pair after an I grant: D first
    expect_issue(32'h9000, 1'b1, WD, cyc + 2);
    expect_issue(32'h8000, 1'b0, '0, cyc + 8);
    mem_rsp.push_back({8{32'h44440009}});
    mem_rsp.push_back({8{32'h55550008}});
    exp_d.push_back({8{32'h44440009}});
    exp_i.push_back({8{32'h55550008}});
    i_strobe_i = 1'b1; i_addr_i = 32'h8000;
    d_strobe_i = 1'b1; d_addr_i = 32'h9000; d_rw_i = 1'b1; d_data_i = WD; tick();
    i_strobe_i = 1'b0; d_strobe_i = 1'b0; d_rw_i = 1'b0;
    wait_cnt(4, 3);
    chk("all_issues_seen", LW'(exp_m.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: address width of all address ports.
REQ-002 Parameter LINE_WIDTH, default 256: width of a cache-line data transfer.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 i_strobe_i  input  1  instruction-cache line-read request, one-cycle pulse.
REQ-006 i_addr_i  input  ADDR_WIDTH  instruction line address, valid with i_strobe_i.
REQ-007 i_done_o  output  1  one-cycle pulse: instruction request complete.
REQ-008 i_data_o  output  LINE_WIDTH  instruction read line, valid while i_done_o is high.
REQ-009 d_strobe_i  input  1  data-cache request, one-cycle pulse.
REQ-010 d_addr_i  input  ADDR_WIDTH  data line address, valid with d_strobe_i.
REQ-011 d_rw_i  input  1  0 = read, 1 = write, valid with d_strobe_i.
REQ-012 d_data_i  input  LINE_WIDTH  write line, valid with d_strobe_i.
REQ-013 d_done_o  output  1  one-cycle pulse: data request complete.
REQ-014 d_data_o  output  LINE_WIDTH  data read line, valid while d_done_o is high.
REQ-015 m_strobe_o  output  1  one-cycle request pulse to the shared memory port.
REQ-016 m_addr_o  output  ADDR_WIDTH  shared-port address.
REQ-017 m_rw_o  output  1  shared-port direction: 0 = read, 1 = write.
REQ-018 m_data_o  output  LINE_WIDTH  shared-port write line.
REQ-019 m_done_i  input  1  shared-port completion pulse.
REQ-020 m_data_i  input  LINE_WIDTH  shared-port read line, valid with m_done_i.

Function
REQ-021 Each requester has a pending flag and a request latch; a strobe in cycle T sets the flag and captures addr (plus rw and data for D) at the edge ending T.
REQ-022 A strobe from a requester whose flag is already set is ignored; the flag and latch are unchanged.
REQ-023 The FSM has the states IDLE, ISSUE, WAIT and RESP.
REQ-024 IDLE: if any flag is set, select a requester and go to ISSUE; otherwise stay in IDLE.
REQ-025 ISSUE: m_strobe_o = 1 for exactly this cycle, then go to WAIT.
REQ-026 WAIT: when m_done_i = 1, register m_data_i into the granted requester's data output and go to RESP.
REQ-027 RESP: the granted requester's done output = 1 for exactly this cycle; its flag clears; go to IDLE.
REQ-028 Arbitration: if only one flag is set, grant that requester; if both are set, grant the requester not granted last (last_grant register).
REQ-029 last_grant updates when IDLE moves to ISSUE; its reset value is D, so the first contested grant goes to I.
REQ-030 m_addr_o, m_rw_o and m_data_o are driven from the granted latch and held stable from ISSUE through WAIT.
REQ-031 For an I grant, m_rw_o = 0 and m_data_o is don't-care.
REQ-032 Latency: a strobe in cycle T with the arbiter in IDLE and no contention gives m_strobe_o in cycle T+2.
REQ-033 Latency: m_done_i in cycle M gives the requester's done in cycle M+1.
REQ-034 m_done_i outside WAIT is ignored.
REQ-035 A strobe in the same cycle as that requester's done leaves its flag set with the new request latched (set wins over clear).
REQ-036 i_data_o and d_data_o hold their last value until the next respective completion.
REQ-037 i_done_o and d_done_o are never high in the same cycle.
REQ-038 At most one shared-port transaction is outstanding at any time.

Reset
REQ-039 rst_n low immediately forces IDLE, clears both flags, sets last_grant = D, and drives m_strobe_o, i_done_o, d_done_o, m_rw_o = 0 and all address and data outputs to 0.
REQ-040 Reset asserted mid-transaction discards the in-flight request; no done pulse is produced after release.

Verification
REQ-041 Single I read: i_strobe_i at T with addr 0x0000_1000 -> m_strobe_o at T+2 with m_addr_o = 0x1000 and m_rw_o = 0; m_done_i with data 0xA5..A5 at M -> i_done_o and i_data_o = 0xA5..A5 at M+1.
REQ-042 D write: d_strobe_i with rw = 1, addr 0x2000, data 0x1234... -> m_rw_o = 1 and m_data_o matches, held through WAIT; d_done_o follows m_done_i by one cycle.
REQ-043 Simultaneous I and D strobes after reset -> I served first, then D.
REQ-044 A second contested pair -> D served first, then I (alternation).
REQ-045 rst_n pulsed low during WAIT -> outputs go to 0 at once; a later m_done_i produces no done pulse.
REQ-046 A duplicate i_strobe_i while pending with a different addr -> the original addr is issued, and i_done_o pulses only once.
